// File: rtl/alu_pkg.sv
// ============================================================================
// Module : alu_pkg
// Brief  : Shared opcode encoding, datapath width and shifter helpers for alu32.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLT  = 4'h5,
        ALU_SLL  = 4'h6,
        ALU_SRL  = 4'h7,
        ALU_SLTU = 4'h8,
        ALU_SRA  = 4'h9
    } alu_op_e;

    localparam logic [1:0] c_SHIFT_SLL = 2'b00;
    localparam logic [1:0] c_SHIFT_SRL = 2'b01;
    localparam logic [1:0] c_SHIFT_SRA = 2'b10;

    function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int k = 0; k < XLEN; k++) begin
            r[k] = v[XLEN-1-k];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_shifter.sv
// ============================================================================
// Module : alu_shifter
// Brief  : Five-stage right barrel shifter; left shifts reuse it via bit reversal.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_shifter
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [4:0]      shamt,
    input  logic [1:0]      mode,
    output logic [XLEN-1:0] y
);

    logic [XLEN-1:0] w_stage [0:5];
    logic            w_fill;

    assign w_fill     = (mode == c_SHIFT_SRA) ? a[XLEN-1] : 1'b0;
    assign w_stage[0] = (mode == c_SHIFT_SLL) ? bit_reverse(a) : a;

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            assign w_stage[gi+1] = shamt[gi]
                ? {{SH{w_fill}}, w_stage[gi][XLEN-1:SH]}
                : w_stage[gi];
        end
    endgenerate

    // Mode 2'b11 is unused by alu32; drive zero rather than leave it undefined.
    always_comb begin
        y = '0;
        case (mode)
            c_SHIFT_SLL: y = bit_reverse(w_stage[5]);
            c_SHIFT_SRL: y = w_stage[5];
            c_SHIFT_SRA: y = w_stage[5];
            default:     y = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu32.sv
// ============================================================================
// Module : alu32
// Brief  : RV32I-style ALU with combinational and registered result/zero.
//          Define ALU_OVERFLOW_EN to add signed-overflow outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu32
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_op,
    output logic [WIDTH-1:0] result,
    output logic             zero,
`ifdef ALU_OVERFLOW_EN
    output logic             overflow,
    output logic             overflow_q,
`endif
    output logic [WIDTH-1:0] result_q,
    output logic             zero_q
);

    alu_op_e          w_op;
    logic [1:0]       w_shift_mode;
    logic [XLEN-1:0]  w_shift_y;
    logic [XLEN-1:0]  w_sum;
    logic [XLEN-1:0]  w_diff;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    assign w_op   = alu_op_e'(alu_op);
    assign w_sum  = a + b;
    assign w_diff = a - b;

    always_comb begin
        w_shift_mode = c_SHIFT_SLL;
        case (w_op)
            ALU_SRL: w_shift_mode = c_SHIFT_SRL;
            ALU_SRA: w_shift_mode = c_SHIFT_SRA;
            default: w_shift_mode = c_SHIFT_SLL;
        endcase
    end

    alu_shifter u_shifter (
        .a     (a),
        .shamt (b[4:0]),
        .mode  (w_shift_mode),
        .y     (w_shift_y)
    );

    // Opcodes 0xA-0xF fall to the default and yield zero.
    always_comb begin
        result = '0;
        case (w_op)
            ALU_ADD:  result = w_sum;
            ALU_SUB:  result = w_diff;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_SLL:  result = w_shift_y;
            ALU_SRL:  result = w_shift_y;
            ALU_SRA:  result = w_shift_y;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_result <= result;
            r_zero   <= zero;
        end
    end

    assign result_q = r_result;
    assign zero_q   = r_zero;

`ifdef ALU_OVERFLOW_EN
    logic r_overflow;

    always_comb begin
        overflow = 1'b0;
        case (w_op)
            ALU_ADD: overflow = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1]  != a[WIDTH-1]);
            ALU_SUB: overflow = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            default: overflow = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= overflow;
        end
    end

    assign overflow_q = r_overflow;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu32.sv
// ============================================================================
// Module : tb_alu32
// Brief  : Directed self-checking bench for alu32 with a registered-path scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu32;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_op;
    logic [31:0] result;
    logic        zero;
    logic [31:0] result_q;
    logic        zero_q;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;
    logic        overflow_q;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        ov;
    } exp_t;

    exp_t sb[$];

    alu32 dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .b          (b),
        .alu_op     (alu_op),
        .result     (result),
        .zero       (zero),
`ifdef ALU_OVERFLOW_EN
        .overflow   (overflow),
        .overflow_q (overflow_q),
`endif
        .result_q   (result_q),
        .zero_q     (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic ovf_model(input logic [3:0] op, input logic [31:0] x,
                                       input logic [31:0] y, input logic [31:0] r);
        if (op == 4'h0) return (x[31] == y[31]) && (r[31] != x[31]);
        if (op == 4'h1) return (x[31] != y[31]) && (r[31] != x[31]);
        return 1'b0;
    endfunction

    // Drive one operation after a falling edge, check the combinational outputs,
    // then check the registered copy one rising edge later.
    task automatic step(input string tag, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] er);
        exp_t e;
        exp_t got;
        @(negedge clk);
        alu_op = op;
        a      = x;
        b      = y;
        #1;
        e.r  = er;
        e.z  = (er == 32'h0);
        e.ov = ovf_model(op, x, y, er);
        chk({tag, ".result"}, result, e.r);
        chk({tag, ".zero"}, {31'h0, zero}, {31'h0, e.z});
`ifdef ALU_OVERFLOW_EN
        chk({tag, ".overflow"}, {31'h0, overflow}, {31'h0, e.ov});
`endif
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s.sb: observed=empty expected=entry", tag);
        end else begin
            got = sb.pop_front();
            chk({tag, ".result_q"}, result_q, got.r);
            chk({tag, ".zero_q"}, {31'h0, zero_q}, {31'h0, got.z});
`ifdef ALU_OVERFLOW_EN
            chk({tag, ".overflow_q"}, {31'h0, overflow_q}, {31'h0, got.ov});
`endif
        end
    endtask

    initial begin
        rst    = 1'b1;
        a      = 32'h0;
        b      = 32'h0;
        alu_op = 4'h0;

        // Reset held for two edges; zero_q clears even though zero is 1.
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("reset.result_q", result_q, 32'h0);
            chk("reset.zero_q", {31'h0, zero_q}, 32'h0);
        end
        chk("reset.zero_comb", {31'h0, zero}, 32'h1);
        @(negedge clk);
        rst = 1'b0;

        step("add_10_20",   4'h0, 32'd10,          32'd20,          32'd30);
        step("add_m10_20",  4'h0, 32'hFFFF_FFF6,   32'd20,          32'd10);
        step("sub_20_20",   4'h1, 32'd20,          32'd20,          32'h0);
        step("sub_20_30",   4'h1, 32'd20,          32'd30,          32'hFFFF_FFF6);
        step("add_ovf",     4'h0, 32'h7FFF_FFFF,   32'd1,           32'h8000_0000);
        step("sub_min_min", 4'h1, 32'h8000_0000,   32'h8000_0000,   32'h0);
        step("sub_ovf",     4'h1, 32'h8000_0000,   32'd1,           32'h7FFF_FFFF);
        step("and",         4'h2, 32'hF0F0_F0F0,   32'h0F0F_0F0F,   32'h0);
        step("or",          4'h3, 32'hF0F0_F0F0,   32'h0F0F_0F0F,   32'hFFFF_FFFF);
        step("xor",         4'h4, 32'hF0F0_F0F0,   32'h0F0F_0F0F,   32'hFFFF_FFFF);
        step("slt_neg",     4'h5, 32'hFFFF_FFFF,   32'd1,           32'd1);
        step("sltu_big",    4'h8, 32'hFFFF_FFFF,   32'd1,           32'd0);
        step("slt_10_20",   4'h5, 32'd10,          32'd20,          32'd1);
        step("sltu_10_20",  4'h8, 32'd10,          32'd20,          32'd1);
        step("slt_20_10",   4'h5, 32'd20,          32'd10,          32'd0);
        step("sll_8_2",     4'h6, 32'd8,           32'd2,           32'd32);
        step("sll_msb",     4'h6, 32'h4000_0000,   32'd1,           32'h8000_0000);
        step("srl_msb",     4'h7, 32'h8000_0000,   32'd4,           32'h0800_0000);
        step("sra_msb",     4'h9, 32'h8000_0000,   32'd4,           32'hF800_0000);
        step("sra_pos",     4'h9, 32'd32,          32'd2,           32'd8);
        step("sll_b23",     4'h6, 32'd1,           32'h23,          32'd8);
        step("srl_b23",     4'h7, 32'h8000_0000,   32'hFFFF_FFE3,   32'h1000_0000);
        step("sra_b23",     4'h9, 32'h8000_0000,   32'h23,          32'hF000_0000);
        step("sll_31",      4'h6, 32'h0000_0003,   32'd31,          32'h8000_0000);
        step("sra_31",      4'h9, 32'h8000_0000,   32'd31,          32'hFFFF_FFFF);

        for (int op = 10; op < 16; op++) begin
            step($sformatf("illegal_%0h", op), op[3:0], 32'd5, 32'd7, 32'h0);
        end

        // Reset asserted mid-stream alongside a live ADD.
        step("pre_rst_add", 4'h0, 32'd10, 32'd20, 32'd30);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst.result_q", result_q, 32'h0);
        chk("midrst.zero_q", {31'h0, zero_q}, 32'h0);
        chk("midrst.result_comb", result, 32'd30);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst.result_q", result_q, 32'd30);
        chk("post_rst.zero_q", {31'h0, zero_q}, 32'h0);

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain: observed=%0d expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu32.md
Name: alu32

Overview:
- 32-bit integer ALU for the RV32I-style single-cycle core datapath; sits between the register-file/immediate muxes and the writeback/branch logic.
- Computes `result` and `zero` combinationally from `a`, `b` and `alu_op`.
- Also provides a registered copy of both outputs for pipelined or multi-cycle consumers.

Parameters:
- WIDTH, 32, datapath width; fixed at 32, shift amount is b[4:0].

Ports:
- clk  input  1  system clock; registered outputs update on rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  32  operand A.
- b  input  32  operand B; shift amount for shift ops.
- alu_op  input  4  operation select.
- result  output  32  combinational result.
- zero  output  1  combinational; 1 when result == 0.
- result_q  output  32  result registered on clk.
- zero_q  output  1  zero registered on clk.

Behaviour:
- Opcode map (alu_op):
  - 0x0 ADD: a+b, modulo 2^32.
  - 0x1 SUB: a−b, modulo 2^32.
  - 0x2 AND.
  - 0x3 OR.
  - 0x4 XOR.
  - 0x5 SLT: signed a<b → 1, else 0; zero-extended to 32 bits.
  - 0x6 SLL: a << b[4:0].
  - 0x7 SRL: logical a >> b[4:0], zero fill.
  - 0x8 SLTU: unsigned a<b → 1, else 0.
  - 0x9 SRA: arithmetic a >>> b[4:0], sign fill from a[31].
  - 0xA–0xF: result = 0 (zero = 1). No other side effect.
- Arithmetic rules:
  - No overflow trapping; wrap silently.
  - Example: 0x7FFFFFFF+1 = 0x80000000.
  - b[31:5] is ignored for all shifts.
- Latency:
  - result/zero: zero-cycle; purely combinational, valid within the same evaluation as input changes. Not gated by clk or rst.
  - result_q/zero_q: capture result/zero on every rising clk edge; one-cycle latency.
- Reset:
  - rst=1 at a rising edge sets result_q=0 and zero_q=0, overriding capture.
  - Reset has no effect on the combinational outputs.
  - Reset asserted mid-stream clears the registers on that edge; capture resumes on the first edge with rst=0.
- No handshake and no state machine.
- No X propagation from unused opcodes; the default case is explicit.

Optional Feature:
- Macro: ALU_OVERFLOW_EN.
- When defined, adds two outputs:
  - `overflow` (1 bit, combinational): signed overflow of ADD (operands same sign, result sign differs) or SUB (operands differ in sign, result sign differs from a). 0 for all other ops.
  - `overflow_q`: its registered copy, reset to 0.
- When undefined: the ports do not exist and the logic is absent.

Decomposition:
- Shared package `alu_pkg` holds:
  - enum `alu_op_e` (4 bits) with ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_XOR=4, ALU_SLT=5, ALU_SLL=6, ALU_SRL=7, ALU_SLTU=8, ALU_SRA=9.
  - localparam XLEN=32.
- One sub-module is natural: `alu_shifter`, a barrel shifter covering SLL/SRL/SRA with inputs a, shamt[4:0] and a 2-bit mode.
- Everything else stays inline in alu32.

Test Plan:
- ADD/SUB:
  - a=10, b=20, ADD → 30, zero=0.
  - a=−10, b=20 → 10.
  - a=20, b=20, SUB → 0, zero=1.
  - a=20, b=30, SUB → 0xFFFFFFF6.
  - a=0x7FFFFFFF, b=1, ADD → 0x80000000 (overflow=1 if enabled).
  - a=b=0x80000000, SUB → 0, zero=1.
- Logic: a=0xF0F0F0F0, b=0x0F0F0F0F → AND 0x00000000 (zero=1), OR 0xFFFFFFFF, XOR 0xFFFFFFFF.
- Compare, a=0xFFFFFFFF, b=1: SLT → 1, SLTU → 0. Also a=10, b=20: SLT → 1 and SLTU → 1.
- Shifts:
  - a=8, b=2, SLL → 32.
  - a=0x40000000, b=1, SLL → 0x80000000.
  - a=0x80000000, b=4: SRL → 0x08000000, SRA → 0xF8000000.
  - a=32, b=2, SRA → 8.
  - b=0x23 behaves as shamt 3.
- Registered path and reset:
  - rst=1 for 2 edges → result_q=0, zero_q=0.
  - Release reset, apply ADD 10+20 → result_q=30 one edge later.
  - Assert rst mid-stream → cleared on that edge while `result` still shows 30.
- Illegal opcodes: alu_op=0xA..0xF with a=5, b=7 → result=0, zero=1.
